// File: rtl/pokey_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pokey_pkg
// Purpose : Shared POKEY register map, script opcodes and FSM state types.
// Rev     : 1.0
// ============================================================================
package pokey_pkg;

    localparam logic [15:0] c_pokey_base = 16'h1000;

    localparam logic [3:0] c_audf1  = 4'h0;
    localparam logic [3:0] c_audc1  = 4'h1;
    localparam logic [3:0] c_audf2  = 4'h2;
    localparam logic [3:0] c_audc2  = 4'h3;
    localparam logic [3:0] c_audf3  = 4'h4;
    localparam logic [3:0] c_audc3  = 4'h5;
    localparam logic [3:0] c_audf4  = 4'h6;
    localparam logic [3:0] c_audc4  = 4'h7;
    localparam logic [3:0] c_audctl = 4'h8;

    localparam logic [1:0] c_op_write = 2'b00;
    localparam logic [1:0] c_op_wait  = 2'b01;
    localparam logic [1:0] c_op_jump  = 2'b10;
    localparam logic [1:0] c_op_end   = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CUE_LO,
        ST_CUE_HI,
        ST_FETCH_OP,
        ST_FETCH_DAT,
        ST_DECODE,
        ST_WRITE,
        ST_WAIT,
        ST_SILENCE,
        ST_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_REQ,
        WR_SETUP,
        WR_HOLD
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/pokey_bus_writer.sv
`default_nettype none
// ============================================================================
// Module  : pokey_bus_writer
// Purpose : One POKEY register write through the request/grant bus port.
// Rev     : 1.0
// ============================================================================
module pokey_bus_writer
    import pokey_pkg::*;
#(
    parameter logic [15:0] POKEY_BASE = c_pokey_base
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clk_en,
    input  logic        i_start,
    input  logic [3:0]  i_reg,
    input  logic [7:0]  i_data,
    input  logic        i_abort,
    input  logic        i_gnt,
    output logic        o_req,
    output logic [15:0] o_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_read,
    output logic        o_busy,
    output logic        o_done
);

    wr_state_t   r_state;
    logic [3:0]  r_reg;
    logic [7:0]  r_data;
    logic        r_req;
    logic [15:0] r_addr;
    logic [7:0]  r_wr_data;
    logic        r_read;
    logic        r_done;

    // Abort only takes effect before grant; once the bus cycle is driven it always completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= WR_IDLE;
            r_reg     <= 4'h0;
            r_data    <= 8'h00;
            r_req     <= 1'b0;
            r_addr    <= 16'h0000;
            r_wr_data <= 8'h00;
            r_read    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                WR_IDLE: begin
                    if (i_start) begin
                        r_reg   <= i_reg;
                        r_data  <= i_data;
                        r_req   <= 1'b1;
                        r_state <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (i_abort) begin
                        r_req   <= 1'b0;
                        r_state <= WR_IDLE;
                    end else if (i_gnt) begin
                        r_addr    <= POKEY_BASE | {12'h000, r_reg};
                        r_wr_data <= r_data;
                        r_read    <= 1'b0;
                        r_state   <= WR_SETUP;
                    end
                end
                WR_SETUP: begin
                    if (i_clk_en) begin
                        r_state <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    r_read  <= 1'b1;
                    r_req   <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= WR_IDLE;
                end
                default: r_state <= WR_IDLE;
            endcase
        end
    end

    assign o_req     = r_req;
    assign o_addr    = r_addr;
    assign o_wr_data = r_wr_data;
    assign o_read    = r_read;
    assign o_busy    = (r_state != WR_IDLE);
    assign o_done    = r_done;

endmodule
`default_nettype wire

// File: rtl/pokey_seq_player.sv
`default_nettype none
// ============================================================================
// Module  : pokey_seq_player
// Purpose : Plays sound-ROM register-write scripts into POKEY over the CPU bus.
// Rev     : 1.0
// ============================================================================
module pokey_seq_player
    import pokey_pkg::*;
#(
    parameter int          ROM_AW     = 12,
    parameter logic [15:0] POKEY_BASE = c_pokey_base
) (
    input  logic              clk_cpu_4x,
    input  logic              reset_cpu_n,
    input  logic              clk_cpu_en,
    input  logic              frame_tick,
    input  logic              start,
    input  logic [3:0]        cue,
    input  logic              stop,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [15:0]       bus_addr,
    output logic [7:0]        bus_wr_data,
    output logic              bus_read,
    output logic              busy,
    output logic              done
);

    localparam logic [ROM_AW-1:0] c_one = ROM_AW'(1);
    localparam logic [ROM_AW-1:0] c_two = ROM_AW'(2);

    seq_state_t        r_state;
    logic [ROM_AW-1:0] r_rom_addr;
    logic [7:0]        r_base_lo;
    logic [ROM_AW-1:0] r_base;
    logic [ROM_AW-1:0] r_ptr;
    logic [1:0]        r_op_kind;
    logic [3:0]        r_op_reg;
    logic [7:0]        r_dat;
    logic [8:0]        r_wait_cnt;
    logic              r_wait_first;
    logic              r_issue;
    logic [3:0]        r_wr_reg;
    logic [7:0]        r_wr_data;
    logic [1:0]        r_sil_idx;
    logic              r_sil_wait;
    logic              r_done;

    logic              w_stop;
    logic              w_wr_start;
    logic              w_wr_busy;
    logic              w_wr_done;
    logic [ROM_AW-1:0] w_dir_lo;
    logic [ROM_AW-1:0] w_base;
    logic [ROM_AW-1:0] w_jump;
    logic              w_unused_bits;

    assign w_dir_lo      = {{(ROM_AW-5){1'b0}}, cue, 1'b0};
    assign w_base        = ROM_AW'({rom_data, r_base_lo});
    assign w_jump        = r_base + ROM_AW'({r_dat, 1'b0});
    assign w_unused_bits = ^rom_data[5:4];

    // Silencing is already the stop response, so stop only acts in the script-playing states.
    assign w_stop     = stop && (r_state != ST_IDLE) && (r_state != ST_SILENCE)
                        && (r_state != ST_DONE);
    assign w_wr_start = r_issue && !w_stop;

    always_ff @(posedge clk_cpu_4x or negedge reset_cpu_n) begin
        if (!reset_cpu_n) begin
            r_state      <= ST_IDLE;
            r_rom_addr   <= '0;
            r_base_lo    <= 8'h00;
            r_base       <= '0;
            r_ptr        <= '0;
            r_op_kind    <= 2'b00;
            r_op_reg     <= 4'h0;
            r_dat        <= 8'h00;
            r_wait_cnt   <= 9'd0;
            r_wait_first <= 1'b0;
            r_issue      <= 1'b0;
            r_wr_reg     <= 4'h0;
            r_wr_data    <= 8'h00;
            r_sil_idx    <= 2'd0;
            r_sil_wait   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_issue <= 1'b0;
            r_done  <= 1'b0;
            if (w_stop) begin
                r_sil_idx  <= 2'd0;
                r_sil_wait <= 1'b0;
                r_state    <= ST_SILENCE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !stop) begin
                            r_rom_addr <= w_dir_lo;
                            r_state    <= ST_CUE_LO;
                        end
                    end
                    ST_CUE_LO: begin
                        r_base_lo  <= rom_data;
                        r_rom_addr <= r_rom_addr + c_one;
                        r_state    <= ST_CUE_HI;
                    end
                    ST_CUE_HI: begin
                        r_base     <= w_base;
                        r_ptr      <= w_base;
                        r_rom_addr <= w_base;
                        r_state    <= ST_FETCH_OP;
                    end
                    ST_FETCH_OP: begin
                        r_op_kind  <= rom_data[7:6];
                        r_op_reg   <= rom_data[3:0];
                        r_rom_addr <= r_ptr + c_one;
                        r_state    <= ST_FETCH_DAT;
                    end
                    ST_FETCH_DAT: begin
                        r_dat   <= rom_data;
                        r_ptr   <= r_ptr + c_two;
                        r_state <= ST_DECODE;
                    end
                    ST_DECODE: begin
                        r_rom_addr <= r_ptr;
                        case (r_op_kind)
                            c_op_write: begin
                                r_wr_reg  <= r_op_reg;
                                r_wr_data <= r_dat;
                                r_issue   <= 1'b1;
                                r_state   <= ST_WRITE;
                            end
                            c_op_wait: begin
                                r_wait_cnt   <= (r_dat == 8'd0) ? 9'd256 : {1'b0, r_dat};
                                r_wait_first <= 1'b1;
                                r_state      <= ST_WAIT;
                            end
                            c_op_jump: begin
                                r_ptr      <= w_jump;
                                r_rom_addr <= w_jump;
                                r_state    <= ST_FETCH_OP;
                            end
                            default: r_state <= ST_DONE;
                        endcase
                    end
                    ST_WRITE: begin
                        if (w_wr_done) begin
                            r_state <= ST_FETCH_OP;
                        end
                    end
                    ST_WAIT: begin
                        r_wait_first <= 1'b0;
                        if (frame_tick && !r_wait_first) begin
                            r_wait_cnt <= r_wait_cnt - 9'd1;
                            if (r_wait_cnt == 9'd1) begin
                                r_state <= ST_FETCH_OP;
                            end
                        end
                    end
                    ST_SILENCE: begin
                        // A write caught mid-cycle by stop drains first; its done is not ours.
                        if (r_sil_wait) begin
                            if (w_wr_done) begin
                                r_sil_wait <= 1'b0;
                                if (r_sil_idx == 2'd3) begin
                                    r_state <= ST_DONE;
                                end else begin
                                    r_sil_idx <= r_sil_idx + 2'd1;
                                end
                            end
                        end else if (!w_wr_busy) begin
                            r_wr_reg   <= {1'b0, r_sil_idx, 1'b1};
                            r_wr_data  <= 8'h00;
                            r_issue    <= 1'b1;
                            r_sil_wait <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    pokey_bus_writer #(
        .POKEY_BASE (POKEY_BASE)
    ) u_writer (
        .clk       (clk_cpu_4x),
        .rst_n     (reset_cpu_n),
        .i_clk_en  (clk_cpu_en),
        .i_start   (w_wr_start),
        .i_reg     (r_wr_reg),
        .i_data    (r_wr_data),
        .i_abort   (w_stop),
        .i_gnt     (bus_gnt),
        .o_req     (bus_req),
        .o_addr    (bus_addr),
        .o_wr_data (bus_wr_data),
        .o_read    (bus_read),
        .o_busy    (w_wr_busy),
        .o_done    (w_wr_done)
    );

    assign rom_addr = r_rom_addr;
    assign busy     = (r_state != ST_IDLE);
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pokey_seq_player.sv
`default_nettype none
// ============================================================================
// Module  : tb_pokey_seq_player
// Purpose : Directed self-checking bench for pokey_seq_player.
// Rev     : 1.0
// ============================================================================
module tb_pokey_seq_player;

    logic        clk = 1'b0;
    logic        reset_cpu_n;
    logic        clk_cpu_en;
    logic        frame_tick;
    logic        start;
    logic [3:0]  cue;
    logic        stop;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic        bus_req;
    logic        bus_gnt;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wr_data;
    logic        bus_read;
    logic        busy;
    logic        done;

    logic [7:0]  rom [0:4095];
    logic        gnt_auto;
    logic [1:0]  en_ph;
    logic [15:0] wa [$];
    logic [7:0]  wd [$];
    int          n_done;
    int          n_vec;
    int          n_err;

    pokey_seq_player #(.ROM_AW(12), .POKEY_BASE(16'h1000)) dut (
        .clk_cpu_4x  (clk),
        .reset_cpu_n (reset_cpu_n),
        .clk_cpu_en  (clk_cpu_en),
        .frame_tick  (frame_tick),
        .start       (start),
        .cue         (cue),
        .stop        (stop),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_read    (bus_read),
        .busy        (busy),
        .done        (done)
    );

    // ROM byte follows the registered address into the next FSM state.
    assign rom_data = rom[rom_addr];
    assign bus_gnt  = gnt_auto & bus_req;

    always #5 clk = ~clk;

    initial begin
        clk_cpu_en = 1'b0;
        en_ph      = 2'd0;
        forever begin
            @(posedge clk);
            #1;
            en_ph      = en_ph + 2'd1;
            clk_cpu_en = (en_ph == 2'd0);
        end
    end

    // Bus-side observer: a write is a clk_cpu_en cycle with bus_read low.
    initial begin
        n_done = 0;
        forever begin
            @(negedge clk);
            if (reset_cpu_n && clk_cpu_en && !bus_read) begin
                wa.push_back(bus_addr);
                wd.push_back(bus_wr_data);
            end
            if (reset_cpu_n && done) n_done = n_done + 1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [3:0] c);
        @(negedge clk);
        start = 1'b1;
        cue   = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic frame(input int gap);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        cycles(gap);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_req(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (bus_req) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        n_done = 0;
    endtask

    initial begin
        bit held_req;
        bit read_low;
        bit any_busy;
        bit seen;
        int bad;
        int n;

        n_vec       = 0;
        n_err       = 0;
        gnt_auto    = 1'b1;
        frame_tick  = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        cue         = 4'h0;
        reset_cpu_n = 1'b0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;

        // directory: cue1 -> 0x100, cue2 -> 0x200, cue3 -> 0x040, cue4 -> 0x300
        rom[2] = 8'h00; rom[3] = 8'h01;
        rom[4] = 8'h00; rom[5] = 8'h02;
        rom[6] = 8'h40; rom[7] = 8'h00;
        rom[8] = 8'h00; rom[9] = 8'h03;
        rom[12'h040] = 8'h00; rom[12'h041] = 8'hA0;
        rom[12'h042] = 8'hC0; rom[12'h043] = 8'h00;
        rom[12'h100] = 8'h40; rom[12'h101] = 8'h03;
        rom[12'h102] = 8'h05; rom[12'h103] = 8'h5A;
        rom[12'h104] = 8'hC0; rom[12'h105] = 8'h00;
        rom[12'h200] = 8'h40; rom[12'h201] = 8'h00;
        rom[12'h202] = 8'h02; rom[12'h203] = 8'h77;
        rom[12'h204] = 8'hC0; rom[12'h205] = 8'h00;
        rom[12'h300] = 8'h06; rom[12'h301] = 8'h33;
        rom[12'h302] = 8'h80; rom[12'h303] = 8'h00;

        // ---- reset state
        cycles(3);
        check("rst_rom_addr", 32'(rom_addr), 32'h0);
        check("rst_bus_req", 32'(bus_req), 32'h0);
        check("rst_bus_addr", 32'(bus_addr), 32'h0);
        check("rst_bus_wr_data", 32'(bus_wr_data), 32'h0);
        check("rst_bus_read", 32'(bus_read), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        reset_cpu_n = 1'b1;
        cycles(2);

        // ---- cue 3: single write then END
        clear_log();
        pulse_start(4'd3);
        check("cue3_busy", 32'(busy), 32'h1);
        check("cue3_dir_lo_addr", 32'(rom_addr), 32'h006);
        cycles(1);
        check("cue3_dir_hi_addr", 32'(rom_addr), 32'h007);
        cycles(1);
        check("cue3_script_addr", 32'(rom_addr), 32'h040);
        wait_done("cue3_done", 200);
        check("cue3_busy_at_done", 32'(busy), 32'h0);
        check("cue3_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() >= 1) begin
            check("cue3_addr", 32'(wa[0]), 32'h1000);
            check("cue3_data", 32'(wd[0]), 32'hA0);
        end
        cycles(1);
        check("cue3_done_one_cycle", 32'(done), 32'h0);
        check("cue3_ndone", 32'(n_done), 32'd1);

        // ---- grant withheld for 20 cycles
        clear_log();
        gnt_auto = 1'b0;
        pulse_start(4'd3);
        cycles(10);
        held_req = 1'b1;
        read_low = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!bus_req) held_req = 1'b0;
            if (!bus_read) read_low = 1'b1;
        end
        check("nogrant_req_held", 32'(held_req), 32'h1);
        check("nogrant_read_high", 32'(read_low), 32'h0);
        check("nogrant_nwrites", 32'(wa.size()), 32'd0);
        gnt_auto = 1'b1;
        wait_done("nogrant_done", 100);
        check("nogrant_nwrites_after", 32'(wa.size()), 32'd1);
        if (wa.size() >= 1) check("nogrant_addr", 32'(wa[0]), 32'h1000);

        // ---- WAIT 3 frames, tick in the entry cycle is ignored
        clear_log();
        cycles(2);
        pulse_start(4'd1);
        cycles(5);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        cycles(4);
        frame(6);
        frame(6);
        cycles(10);
        check("wait3_no_req_after_2", 32'(bus_req), 32'h0);
        check("wait3_busy", 32'(busy), 32'h1);
        frame(0);
        wait_req("wait3_req_after_3", 20);
        wait_done("wait3_done", 100);
        check("wait3_nwrites", 32'(wa.size()), 32'd1);
        if (wa.size() >= 1) begin
            check("wait3_addr", 32'(wa[0]), 32'h1005);
            check("wait3_data", 32'(wd[0]), 32'h5A);
        end

        // ---- WAIT 0 means 256 frames
        clear_log();
        cycles(2);
        pulse_start(4'd2);
        cycles(10);
        for (int k = 0; k < 255; k++) frame(1);
        cycles(10);
        check("wait256_no_req_255", 32'(bus_req), 32'h0);
        check("wait256_nwrites_255", 32'(wa.size()), 32'd0);
        frame(0);
        wait_req("wait256_req_256", 20);
        wait_done("wait256_done", 100);
        if (wa.size() >= 1) check("wait256_addr", 32'(wa[0]), 32'h1002);

        // ---- JUMP loop: write repeats, no done; then stop silences
        clear_log();
        cycles(2);
        pulse_start(4'd4);
        cycles(200);
        check("loop_many_writes", 32'(wa.size() >= 5), 32'h1);
        bad = 0;
        foreach (wa[i]) if (wa[i] !== 16'h1006 || wd[i] !== 8'h33) bad = bad + 1;
        check("loop_write_values", 32'(bad), 32'd0);
        check("loop_no_done", 32'(n_done), 32'd0);
        check("loop_busy", 32'(busy), 32'h1);
        clear_log();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done("loop_stop_done", 300);
        n = wa.size();
        check("loop_stop_nwrites_ok", 32'(n == 4 || n == 5), 32'h1);
        if (n >= 4) check("loop_stop_last_audc4", 32'(wa[n-1]), 32'h1007);

        // ---- stop during WAIT -> silence AUDC1..4
        clear_log();
        cycles(2);
        pulse_start(4'd1);
        cycles(12);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done("stopwait_done", 300);
        check("stopwait_busy", 32'(busy), 32'h0);
        check("stopwait_nwrites", 32'(wa.size()), 32'd4);
        if (wa.size() == 4) begin
            check("stopwait_w0", {wa[0], 8'h00, wd[0]}, {16'h1001, 16'h0000});
            check("stopwait_w1", {wa[1], 8'h00, wd[1]}, {16'h1003, 16'h0000});
            check("stopwait_w2", {wa[2], 8'h00, wd[2]}, {16'h1005, 16'h0000});
            check("stopwait_w3", {wa[3], 8'h00, wd[3]}, {16'h1007, 16'h0000});
        end

        // ---- start and stop together from IDLE
        clear_log();
        cycles(2);
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        cue   = 4'd3;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        any_busy = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy || bus_req) any_busy = 1'b1;
        end
        check("startstop_no_activity", 32'(any_busy), 32'h0);
        check("startstop_nwrites", 32'(wa.size()), 32'd0);

        // ---- async reset in the middle of a write
        clear_log();
        pulse_start(4'd3);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (!bus_read) seen = 1'b1;
        end
        check("rstmid_reached_setup", 32'(seen), 32'h1);
        #1;
        reset_cpu_n = 1'b0;
        #1;
        check("rstmid_bus_read", 32'(bus_read), 32'h1);
        check("rstmid_bus_req", 32'(bus_req), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset_cpu_n = 1'b1;
        cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
